// File: rtl/branch_resolve_queue.sv
// In-flight branch prediction queue: trains the predictor on resolve, recovers history on mispredict.
// Optional macro BRQ_PC_CHECK_EN: compare resolve_pc against the head entry and flag mismatches.
module branch_resolve_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned HISTORY_SIZE = 64,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_valid,
  input  logic [ADDR_WIDTH-1:0]        alloc_pc,
  input  logic                         alloc_prediction,
  input  logic [HISTORY_SIZE-1:0]      alloc_history,
  output logic                         alloc_ready,
  input  logic                         resolve_valid,
  input  logic [ADDR_WIDTH-1:0]        resolve_pc,
  input  logic                         resolve_taken,
  input  logic                         flush,
  output logic                         train_valid,
  output logic [ADDR_WIDTH-1:0]        train_pc,
  output logic [HISTORY_SIZE-1:0]      train_history,
  output logic                         train_prediction,
  output logic                         train_taken,
  output logic                         mispredict,
  output logic [HISTORY_SIZE-1:0]      recover_history,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         pc_mismatch
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0]   pc_mem_q   [DEPTH];
  logic [HISTORY_SIZE-1:0] hist_mem_q [DEPTH];
  logic                    pred_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic                    train_valid_q, mispredict_q;
  logic [ADDR_WIDTH-1:0]   train_pc_q;
  logic [HISTORY_SIZE-1:0] train_history_q, recover_q;
  logic                    train_prediction_q, train_taken_q;

  logic [ADDR_WIDTH-1:0]   head_pc;
  logic [HISTORY_SIZE-1:0] head_hist;
  logic                    head_pred;
  logic                    pop, pc_ok, train_fire, mispred, push;

  assign head_pc   = pc_mem_q[head_q];
  assign head_hist = hist_mem_q[head_q];
  assign head_pred = pred_mem_q[head_q];

  assign alloc_ready = (count_q != CW'(DEPTH));

  // Flush wins over everything; an empty-queue resolve is ignored entirely.
  assign pop = resolve_valid && (count_q != '0) && !flush;

`ifdef BRQ_PC_CHECK_EN
  assign pc_ok = (resolve_pc == head_pc);
`else
  logic unused_resolve_pc;
  assign unused_resolve_pc = ^resolve_pc;
  assign pc_ok = 1'b1;
`endif

  assign train_fire = pop && pc_ok;
  assign mispred    = train_fire && (head_pred != resolve_taken);
  // Allocations in the mispredict cycle belong to the wrong path and are dropped.
  assign push       = alloc_valid && alloc_ready && !flush && !mispred;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush || mispred) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]   <= alloc_pc;
      hist_mem_q[tail_q] <= alloc_history;
      pred_mem_q[tail_q] <= alloc_prediction;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      train_valid_q      <= 1'b0;
      mispredict_q       <= 1'b0;
      train_pc_q         <= '0;
      train_history_q    <= '0;
      train_prediction_q <= 1'b0;
      train_taken_q      <= 1'b0;
      recover_q          <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      train_valid_q <= train_fire;
      mispredict_q  <= mispred;
      if (train_fire) begin
        train_pc_q         <= head_pc;
        train_history_q    <= head_hist;
        train_prediction_q <= head_pred;
        train_taken_q      <= resolve_taken;
      end
      // Newest actual outcome shifts into the LSB of the snapshot.
      if (mispred) recover_q <= {head_hist[HISTORY_SIZE-2:0], resolve_taken};
    end
  end

`ifdef BRQ_PC_CHECK_EN
  logic pc_mismatch_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_mismatch_q <= 1'b0;
    else        pc_mismatch_q <= pop && !pc_ok;
  end
  assign pc_mismatch = pc_mismatch_q;
`else
  assign pc_mismatch = 1'b0;
`endif

  assign train_valid      = train_valid_q;
  assign train_pc         = train_pc_q;
  assign train_history    = train_history_q;
  assign train_prediction = train_prediction_q;
  assign train_taken      = train_taken_q;
  assign mispredict       = mispredict_q;
  assign recover_history  = recover_q;
  assign count            = count_q;

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning in-flight prediction entries (power of 2, >=2).
REQ-002 SHALL have parameter HISTORY_SIZE, default 64, meaning global-history snapshot width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning branch PC width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port alloc_valid  in  1  decode-stage prediction issued.
REQ-007 SHALL have port alloc_pc  in  ADDR_WIDTH  PC of predicted branch.
REQ-008 SHALL have port alloc_prediction  in  1  predicted direction, 1 = taken.
REQ-009 SHALL have port alloc_history  in  HISTORY_SIZE  history used for the prediction.
REQ-010 SHALL have port alloc_ready  out  1  queue not full.
REQ-011 SHALL have port resolve_valid  in  1  EX-stage branch resolved.
REQ-012 SHALL have port resolve_pc  in  ADDR_WIDTH  PC of resolved branch.
REQ-013 SHALL have port resolve_taken  in  1  actual direction.
REQ-014 SHALL have port flush  in  1  pipeline flush, discard all entries.
REQ-015 SHALL have port train_valid  out  1  one-cycle training pulse.
REQ-016 SHALL have ports train_pc (ADDR_WIDTH), train_history (HISTORY_SIZE), train_prediction (1), train_taken (1)  out  training payload.
REQ-017 SHALL have port mispredict  out  1  one-cycle pulse, prediction wrong.
REQ-018 SHALL have port recover_history  out  HISTORY_SIZE  corrected history, valid with mispredict.
REQ-019 SHALL have port count  out  $clog2(DEPTH+1)  occupied entries.
REQ-020 SHALL have port pc_mismatch  out  1  one-cycle pulse, resolve PC not head PC.

Function
REQ-021 SHALL store entries in program order as a circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-022 SHALL drive alloc_ready = (count != DEPTH), registered-state only, no combinational path from resolve_valid.
REQ-023 SHALL write an entry on alloc_valid && alloc_ready; alloc_valid while full is dropped, count unchanged.
REQ-024 SHALL pop the head on resolve_valid when count > 0; resolve_valid with count == 0 ignored, no outputs asserted.
REQ-025 SHALL assert train_valid and payload registered exactly 1 cycle after a popping resolve; payload = head pc/history/prediction plus resolve_taken.
REQ-026 SHALL assert mispredict in the same cycle as train_valid when head prediction != resolve_taken.
REQ-027 SHALL set recover_history = {head history[HISTORY_SIZE-2:0], resolve_taken} (newest outcome in LSB) when mispredict asserts; otherwise hold.
REQ-028 SHALL on a mispredicting resolve discard all younger entries: count becomes 0 next cycle, same-cycle alloc dropped.
REQ-029 SHALL on simultaneous alloc and non-mispredicting resolve perform both; count unchanged.
REQ-030 SHALL on flush clear count/pointers next cycle; flush overrides same-cycle alloc and resolve (no train_valid, no mispredict).
REQ-031 SHALL hold train_valid, mispredict, pc_mismatch low in every cycle not listed above.

Reset
REQ-032 SHALL on rst_n low immediately clear pointers, count = 0, alloc_ready = 1, train_valid = mispredict = pc_mismatch = 0, train payload and recover_history = 0.
REQ-033 SHALL discard all entries on reset mid-operation; no pulse on first cycle after release.

Configuration
REQ-034 SHALL honour macro BRQ_PC_CHECK_EN: defined -> resolve_pc compared to head pc; on mismatch head popped, pc_mismatch pulses 1 cycle later, no train_valid/mispredict; undefined -> resolve_pc ignored, pc_mismatch tied 0.

Verification
REQ-035 SHALL cover: 4 allocs (pc 0x100..0x10C, pred 1) then 4 resolves taken=1 -> train_valid x4 in order, mispredict 0, count 4->0.
REQ-036 SHALL cover: full queue, alloc pc 0x200 -> dropped, alloc_ready 0; next resolve pops 0x100 not 0x200.
REQ-037 SHALL cover: 3 entries, head pred 1, resolve taken=0, history 0x...0005 -> mispredict 1, recover_history 0x...000A, count 0.
REQ-038 SHALL cover: alloc + resolve same cycle with count 2, correct prediction -> count stays 2, wrap-around across pointer DEPTH-1 -> 0.
REQ-039 SHALL cover: flush with 2 entries plus simultaneous resolve -> no train_valid, count 0; rst_n pulse mid-stream -> all outputs 0.
REQ-040 SHALL cover with BRQ_PC_CHECK_EN: head 0x100, resolve_pc 0x104 -> pc_mismatch 1, train_valid 0, count decremented.
